// File: rtl/sfx_sequencer.sv
// sfx_sequencer: plays short tone sequences for game events from an internal ROM.
// Each ROM entry is (freq, units); one unit lasts BEAT_DIV clocks. After the
// end marker the block holds silence for one extra unit (TAIL) before idling.
// Ports:
//   clk, rst_n            clock, async active-low reset
//   evt_hit/miss/over     one-cycle event pulses (priority over > miss > hit)
//   mute                  forces volume to 0, timing untouched
//   freq_hz               registered note frequency, 50000000 = silence
//   volume                VOL while a note sounds and not muted
//   busy                  high while a sequence (including TAIL) is active
//   note_strobe           one-cycle pulse whenever a new ROM entry loads
module sfx_sequencer #(
  parameter int unsigned BEAT_DIV = 6250000,
  parameter logic [2:0]  VOL      = 3'd3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        evt_hit,
  input  logic        evt_miss,
  input  logic        evt_over,
  input  logic        mute,
  output logic [31:0] freq_hz,
  output logic [2:0]  volume,
  output logic        busy,
  output logic        note_strobe
);
  localparam int          BW        = $clog2(BEAT_DIV);
  localparam logic [BW-1:0] BEAT_LAST = BW'(BEAT_DIV - 1);
  localparam logic [31:0] SIL       = 32'd50000000;

  typedef enum logic [1:0] {IDLE, PLAY, TAIL} state_t;

  // ROM: {units, freq}; units == 0 is the end marker of a sequence.
  // HIT at 0, MISS at 3, OVER at 7.
  function automatic logic [35:0] rom(input logic [3:0] a);
    case (a)
      4'd0:  rom = {4'd2, 32'd659};
      4'd1:  rom = {4'd2, 32'd784};
      4'd3:  rom = {4'd3, 32'd262};
      4'd4:  rom = {4'd1, SIL};
      4'd5:  rom = {4'd3, 32'd262};
      4'd7:  rom = {4'd4, 32'd392};
      4'd8:  rom = {4'd4, 32'd330};
      4'd9:  rom = {4'd8, 32'd262};
      default: rom = 36'd0;
    endcase
  endfunction

  state_t        state_q, state_d;
  logic [1:0]    seq_q, seq_d;
  logic [3:0]    addr_q, addr_d;
  logic [BW-1:0] beat_q, beat_d;
  logic [3:0]    unit_q, unit_d;
  logic [31:0]   freq_q, freq_d;
  logic [2:0]    vol_q, vol_d;
  logic          busy_q, busy_d;
  logic          stb_q, stb_d;

  logic          evt_any;
  logic [1:0]    evt_pri;
  logic [3:0]    base;
  logic          accept;
  logic [35:0]   ent;

  always_comb begin
    state_d = state_q;
    seq_d   = seq_q;
    addr_d  = addr_q;
    beat_d  = beat_q;
    unit_d  = unit_q;
    freq_d  = freq_q;
    stb_d   = 1'b0;
    ent     = 36'd0;

    evt_any = evt_hit | evt_miss | evt_over;
    evt_pri = evt_over ? 2'd2 : (evt_miss ? 2'd1 : 2'd0);
    base    = evt_over ? 4'd7 : (evt_miss ? 4'd3 : 4'd0);
    // TAIL is already past the musical part, so any event may take over.
    accept  = evt_any && (state_q != PLAY || evt_pri >= seq_q);

    if (accept) begin
      ent     = rom(base);
      addr_d  = base;
      seq_d   = evt_pri;
      freq_d  = ent[31:0];
      unit_d  = ent[35:32] - 4'd1;
      beat_d  = BEAT_LAST;
      state_d = PLAY;
      stb_d   = 1'b1;
    end else begin
      case (state_q)
        PLAY: begin
          if (beat_q != '0) begin
            beat_d = beat_q - 1'b1;
          end else if (unit_q != 4'd0) begin
            unit_d = unit_q - 4'd1;
            beat_d = BEAT_LAST;
          end else begin
            // terminal count: next entry loads on this same edge
            ent = rom(addr_q + 4'd1);
            if (ent[35:32] == 4'd0) begin
              state_d = TAIL;
              freq_d  = SIL;
              beat_d  = BEAT_LAST;
              unit_d  = 4'd0;
            end else begin
              addr_d = addr_q + 4'd1;
              freq_d = ent[31:0];
              unit_d = ent[35:32] - 4'd1;
              beat_d = BEAT_LAST;
              stb_d  = 1'b1;
            end
          end
        end
        TAIL: begin
          if (beat_q != '0) beat_d = beat_q - 1'b1;
          else              state_d = IDLE;
        end
        default: begin
          beat_d = '0;
          unit_d = 4'd0;
          freq_d = SIL;
        end
      endcase
    end

    vol_d  = (state_d == PLAY && freq_d != SIL && !mute) ? VOL : 3'd0;
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      seq_q   <= 2'd0;
      addr_q  <= 4'd0;
      beat_q  <= '0;
      unit_q  <= 4'd0;
      freq_q  <= SIL;
      vol_q   <= 3'd0;
      busy_q  <= 1'b0;
      stb_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      seq_q   <= seq_d;
      addr_q  <= addr_d;
      beat_q  <= beat_d;
      unit_q  <= unit_d;
      freq_q  <= freq_d;
      vol_q   <= vol_d;
      busy_q  <= busy_d;
      stb_q   <= stb_d;
    end
  end

  assign freq_hz     = freq_q;
  assign volume      = vol_q;
  assign busy        = busy_q;
  assign note_strobe = stb_q;
endmodule

// File: tb/tb_sfx_sequencer.sv
// Bench for sfx_sequencer with BEAT_DIV=4. A sequence-level model expands each
// accepted event into a per-cycle list of expected outputs; a compare process
// checks every cycle, and directed literal checks pin the model.
module tb_sfx_sequencer;
  localparam int BD = 4;
  localparam logic [31:0] SIL = 32'd50000000;

  logic clk = 1'b0, rst_n = 1'b0;
  logic evt_hit = 1'b0, evt_miss = 1'b0, evt_over = 1'b0, mute = 1'b0;
  logic [31:0] freq_hz;
  logic [2:0]  volume;
  logic        busy, note_strobe;

  int checks = 0, errors = 0;

  sfx_sequencer #(.BEAT_DIV(BD), .VOL(3'd3)) dut (
    .clk(clk), .rst_n(rst_n), .evt_hit(evt_hit), .evt_miss(evt_miss),
    .evt_over(evt_over), .mute(mute), .freq_hz(freq_hz), .volume(volume),
    .busy(busy), .note_strobe(note_strobe));

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] f;
    bit snd, bsy, stb, tail;
    int seq;
  } exp_t;

  exp_t q[$];
  exp_t cur;
  bit   cur_mute = 1'b0;

  function automatic exp_t idle_e();
    exp_t e;
    e.f = SIL; e.snd = 0; e.bsy = 0; e.stb = 0; e.tail = 0; e.seq = -1;
    return e;
  endfunction

  // sequence table: s = 0 hit, 1 miss, 2 over; u = 0 marks end
  task automatic seq_ent(input int s, input int i, output int f, output int u);
    f = 0; u = 0;
    case (s)
      0: case (i) 0: begin f = 659; u = 2; end 1: begin f = 784; u = 2; end default: ; endcase
      1: case (i) 0: begin f = 262; u = 3; end 1: begin f = SIL; u = 1; end
                  2: begin f = 262; u = 3; end default: ; endcase
      default: case (i) 0: begin f = 392; u = 4; end 1: begin f = 330; u = 4; end
                        2: begin f = 262; u = 8; end default: ; endcase
    endcase
  endtask

  task automatic expand(input int s);
    int f, u;
    exp_t e;
    q.delete();
    for (int i = 0; i < 8; i++) begin
      seq_ent(s, i, f, u);
      if (u == 0) break;
      for (int c = 0; c < u * BD; c++) begin
        e.f = f; e.snd = (f != SIL); e.bsy = 1; e.stb = (c == 0); e.tail = 0; e.seq = s;
        q.push_back(e);
      end
    end
    for (int c = 0; c < BD; c++) begin
      e.f = SIL; e.snd = 0; e.bsy = 1; e.stb = 0; e.tail = 1; e.seq = s;
      q.push_back(e);
    end
  endtask

  initial cur = idle_e();

  always @(negedge rst_n) begin
    q.delete();
    cur = idle_e();
  end

  always @(posedge clk) begin
    int p;
    p = evt_over ? 2 : (evt_miss ? 1 : (evt_hit ? 0 : -1));
    if (!rst_n) begin
      q.delete();
      cur = idle_e();
    end else begin
      if (p >= 0 && (!cur.bsy || cur.tail || p >= cur.seq)) expand(p);
      if (q.size() > 0) cur = q.pop_front();
      else              cur = idle_e();
    end
    cur_mute = mute;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0d exp=%0d t=%0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    e = rst_n ? cur : idle_e();
    chk("m_freq", freq_hz, e.f);
    chk("m_vol", {29'd0, volume}, (e.snd && !cur_mute) ? 32'd3 : 32'd0);
    chk("m_busy", {31'd0, busy}, {31'd0, e.bsy});
    chk("m_strobe", {31'd0, note_strobe}, {31'd0, e.stb});
  end

  task automatic wcyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // called at a negedge; the following posedge samples the event
  task automatic pulse(input logic h, input logic m, input logic o);
    evt_hit = h; evt_miss = m; evt_over = o;
    @(negedge clk);
    evt_hit = 0; evt_miss = 0; evt_over = 0;
  endtask

  initial begin
    wcyc(2);
    chk("rst_freq", freq_hz, SIL);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_vol", {29'd0, volume}, 32'd0);
    rst_n = 1'b1;
    wcyc(2);

    // HIT
    pulse(1, 0, 0);
    chk("hit_c1_freq", freq_hz, 32'd659);
    chk("hit_c1_stb", {31'd0, note_strobe}, 32'd1);
    chk("hit_c1_vol", {29'd0, volume}, 32'd3);
    wcyc(7);  chk("hit_c8_freq", freq_hz, 32'd659);
    wcyc(1);  chk("hit_c9_freq", freq_hz, 32'd784);
    chk("hit_c9_stb", {31'd0, note_strobe}, 32'd1);
    wcyc(8);  chk("hit_c17_freq", freq_hz, SIL);
    chk("hit_c17_busy", {31'd0, busy}, 32'd1);
    wcyc(3);  chk("hit_c20_busy", {31'd0, busy}, 32'd1);
    wcyc(1);  chk("hit_c21_busy", {31'd0, busy}, 32'd0);
    wcyc(3);

    // MISS
    pulse(0, 1, 0);
    chk("miss_c1_freq", freq_hz, 32'd262);
    wcyc(12); chk("miss_c13_vol", {29'd0, volume}, 32'd0);
    chk("miss_c13_stb", {31'd0, note_strobe}, 32'd1);
    wcyc(4);  chk("miss_c17_freq", freq_hz, 32'd262);
    chk("miss_c17_vol", {29'd0, volume}, 32'd3);
    wcyc(16); chk("miss_c33_busy", {31'd0, busy}, 32'd0);
    wcyc(2);

    // HIT + OVER together
    pulse(1, 0, 1);
    chk("ho_c1_freq", freq_hz, 32'd392);
    wcyc(16); chk("ho_c17_freq", freq_hz, 32'd330);
    wcyc(16); chk("ho_c33_freq", freq_hz, 32'd262);
    wcyc(32); chk("ho_c65_freq", freq_hz, SIL);
    chk("ho_c65_busy", {31'd0, busy}, 32'd1);
    wcyc(4);  chk("ho_c69_busy", {31'd0, busy}, 32'd0);
    wcyc(2);

    // MISS then lower-priority HIT: ignored
    pulse(0, 1, 0);
    wcyc(4);
    pulse(1, 0, 0);
    chk("mh_freq", freq_hz, 32'd262);
    chk("mh_stb", {31'd0, note_strobe}, 32'd0);
    wcyc(40);

    // MISS then OVER: restart
    pulse(0, 1, 0);
    wcyc(4);
    pulse(0, 0, 1);
    chk("mo_freq", freq_hz, 32'd392);
    chk("mo_stb", {31'd0, note_strobe}, 32'd1);
    wcyc(72);

    // mute through HIT
    mute = 1'b1;
    pulse(1, 0, 0);
    chk("mute_freq", freq_hz, 32'd659);
    chk("mute_vol", {29'd0, volume}, 32'd0);
    wcyc(24);
    mute = 1'b0;
    wcyc(2);

    // low-priority event during TAIL is accepted
    pulse(0, 0, 1);
    wcyc(64);
    chk("tail_freq", freq_hz, SIL);
    wcyc(1);
    pulse(1, 0, 0);
    chk("tail_hit_freq", freq_hz, 32'd659);
    chk("tail_hit_stb", {31'd0, note_strobe}, 32'd1);
    wcyc(30);

    // equal priority restarts
    pulse(1, 0, 0);
    wcyc(2);
    pulse(1, 0, 0);
    chk("eq_stb", {31'd0, note_strobe}, 32'd1);
    wcyc(30);

    // mute toggled mid-note
    pulse(0, 1, 0);
    wcyc(2);
    mute = 1'b1;
    wcyc(1);
    chk("mt_vol", {29'd0, volume}, 32'd0);
    chk("mt_freq", freq_hz, 32'd262);
    mute = 1'b0;
    wcyc(1);
    chk("mt_vol2", {29'd0, volume}, 32'd3);
    wcyc(34);

    // async reset mid-OVER, events during reset lost
    pulse(0, 0, 1);
    wcyc(10);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_freq", freq_hz, SIL);
    chk("ar_busy", {31'd0, busy}, 32'd0);
    chk("ar_vol", {29'd0, volume}, 32'd0);
    chk("ar_stb", {31'd0, note_strobe}, 32'd0);
    @(negedge clk);
    evt_over = 1'b1;
    @(negedge clk);
    evt_over = 1'b0;
    rst_n = 1'b1;
    wcyc(10);
    chk("post_busy", {31'd0, busy}, 32'd0);
    chk("post_freq", freq_hz, SIL);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout act=%0d exp=%0d", 1, 0);
    $fatal(1, "timeout");
  end
endmodule

// File: doc/sfx_sequencer.md
SFX_SEQUENCER -- requirements
Module: sfx_sequencer

Interface
REQ-001 Parameter BEAT_DIV, default 6250000, clock cycles per duration unit (62.5 ms at 100 MHz); legal range 2..2^26-1.
REQ-002 Parameter VOL, default 3, volume level driven while a note sounds; 3 bits.
REQ-003 clk  input  1  single system clock; all state on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low; no other reset exists.
REQ-005 evt_hit  input  1  one-cycle pulse, mole hit.
REQ-006 evt_miss  input  1  one-cycle pulse, life lost.
REQ-007 evt_over  input  1  one-cycle pulse, game over.
REQ-008 mute  input  1  level; forces volume to 0, sequencing unaffected.
REQ-009 freq_hz  output  32  note frequency in Hz for the downstream tone stage; silence = 50000000.
REQ-010 volume  output  3  VOL while a note sounds and mute=0, else 0.
REQ-011 busy  output  1  high from the cycle after trigger until return to IDLE.
REQ-012 note_strobe  output  1  one-cycle pulse on every cycle a new ROM entry is loaded, including the first.

Function
REQ-013 Internal ROM, entries (freq, units); units 1..15; units=0 marks end of sequence.
REQ-014 HIT sequence: (659,2) (784,2) end.
REQ-015 MISS sequence: (262,3) (50000000,1) (262,3) end.
REQ-016 OVER sequence: (392,4) (330,4) (262,8) end.
REQ-017 Priority OVER(2) > MISS(1) > HIT(0); simultaneous pulses: highest only; others dropped.
REQ-018 States IDLE, PLAY, TAIL.
REQ-019 IDLE: freq_hz=50000000, volume=0, busy=0.
REQ-020 Event sampled at edge k: at edge k, registers freq_hz=first entry freq, state=PLAY, busy=1, note_strobe=1 for the following cycle, beat and unit counters loaded.
REQ-021 PLAY: each entry holds exactly units*BEAT_DIV cycles; at terminal count next entry loads on the same edge, zero gap cycles.
REQ-022 Silence entry (freq 50000000) in PLAY drives volume=0.
REQ-023 End marker reached at terminal count: freq_hz=50000000, volume=0, state=TAIL, busy stays 1, no note_strobe.
REQ-024 TAIL lasts exactly BEAT_DIV cycles, then IDLE, busy=0.
REQ-025 Event during PLAY or TAIL with priority >= current sequence: restart that event's sequence per REQ-020 (counters reloaded, note_strobe pulses).
REQ-026 Event with priority < current sequence during PLAY: ignored; during TAIL: accepted regardless of priority.
REQ-027 Beat counter width ceil(log2(BEAT_DIV)); unit counter 4 bits; no wrap; counters held at 0 in IDLE.
REQ-028 All outputs registered; no combinational path from inputs to outputs.
REQ-029 mute toggles mid-note change volume on the next edge only; freq_hz, busy, timing unaffected.

Reset
REQ-030 rst_n=0 forces immediately, without clock: state=IDLE, freq_hz=50000000, volume=0, busy=0, note_strobe=0, all counters 0.
REQ-031 Reset mid-sequence aborts it; events pulsed while rst_n=0 are lost; first event accepted on the first edge with rst_n=1.

Verification (BEAT_DIV=4)
REQ-032 evt_hit at edge 0 -> freq_hz 659 cycles 1-8, 784 cycles 9-16, 50000000 with busy=1 cycles 17-20, busy=0 from 21; note_strobe at cycles 1 and 9.
REQ-033 evt_miss -> 262 for 12 cycles, volume 0 for 4 cycles, 262 for 12 cycles, 4-cycle TAIL; three note_strobe pulses.
REQ-034 evt_hit and evt_over same edge -> OVER sequence only: 392(16) 330(16) 262(32), TAIL 4.
REQ-035 evt_miss, then evt_hit 5 cycles later -> hit ignored, MISS completes unchanged; evt_over 5 cycles into MISS -> OVER restarts next edge, note_strobe=1.
REQ-036 mute=1 through HIT sequence -> volume=0 throughout, freq_hz and busy timing identical to REQ-032.
REQ-037 rst_n low asynchronously mid-OVER -> outputs at reset values before next clock edge; after release, no activity until a new event.
